alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU interface: accepts one MIPS instruction plus register operands per
//  handshake, decodes it into A/B/ALUOp, drives the external combinational ALU, captures C and
//  returns the result through a valid/ready response port. Sits between operand fetch and writeback
//  in the multi-cycle datapath. One instruction in flight; no internal queue.
// PARAMETERS
//  (none; widths fixed: data 32, ALUOp 3)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   controller can accept (high only in IDLE)
//  req_instr    in   32  MIPS instruction word
//  req_rs_val   in   32  GPR[rs] value
//  req_rt_val   in   32  GPR[rt] value
//  alu_a        out  32  ALU operand A (registered)
//  alu_b        out  32  ALU operand B (registered)
//  alu_op       out  3   ALUOp: 000 add,001 sub,010 and,011 or,100 srl,101 sra (registered)
//  alu_c        in   32  ALU result (combinational from alu_a/alu_b/alu_op)
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer accepts response
//  rsp_data     out  32  captured ALU result (0 on error)
//  rsp_err      out  1   illegal instruction (or overflow when OVERFLOW_TRAP_EN)
// BEHAVIOUR
//  - Reset (reset==0, any time incl. mid-op): state IDLE; alu_a/alu_b/rsp_data=0, alu_op=000,
//    rsp_valid=0, rsp_err=0; req_ready=1 after reset releases. In-flight request is dropped.
//  - FSM IDLE->EXEC->RESP->IDLE; illegal: IDLE->RESP directly.
//  - IDLE: req_ready=1. On req_valid&req_ready at edge N: decode, register alu_a/alu_b/alu_op, ->EXEC.
//  - EXEC (one cycle): alu_c sampled at edge N+1 into rsp_data, rsp_err=0, ->RESP.
//  - RESP: rsp_valid=1 from after edge N+2-1 (i.e. visible in cycle after N+1); rsp_data/rsp_err held
//    stable until rsp_valid&rsp_ready; at that edge ->IDLE, rsp_valid=0. Latency accept->valid = 2 edges.
//  - req_ready=0 in EXEC and RESP; req_valid ignored there. No back-to-back accept in RESP-exit cycle.
//  - Decode (op=instr[31:26], funct=instr[5:0], shamt=instr[10:6], imm=instr[15:0]):
//    R(op=0): addu 0x21 A=rs B=rt 000; subu 0x23 001; and 0x24 010; or 0x25 011;
//     srl 0x02 A=rt B=zext(shamt) 100; sra 0x03 101; srlv 0x06 A=rt B=zext(rs[4:0]) 100; srav 0x07 101.
//    I: addiu 0x09 A=rs B=sext(imm) 000; andi 0x0c B=zext(imm) 010; ori 0x0d B=zext(imm) 011.
//    Anything else: illegal -> rsp_err=1, rsp_data=0, alu_* unchanged, ->RESP in one edge.
//  - All arithmetic mod 2^32; controller never inspects alu_c beyond capture (except overflow option).
// CONFIGURATION
//  OVERFLOW_TRAP_EN defined: add 0x20 / sub 0x22 (R) and addi 0x08 (I, sext) are legal, ALUOp 000/001;
//   in EXEC signed overflow (sign(A)==sign(B') && sign(C)!=sign(A), B'=B or ~B+1 for sub) sets
//   rsp_err=1, rsp_data=0. Unsigned forms never trap.
//  Not defined: 0x20/0x22/0x08 are illegal (rsp_err=1); no overflow logic synthesized.
// STRUCTURE
//  Package alu_ctrl_pkg: ALUOp constants (ALU_ADD..ALU_SRA), opcode/funct constants, FSM state
//  encoding (S_IDLE,S_EXEC,S_RESP). Sub-module alu_issue_decode: combinational instr+operands ->
//  {a,b,op,illegal}; top holds FSM, registers, handshake.
// TESTING (bench models ALU per ALUOp table)
//  - reset low mid-EXEC after addu accept -> next cycle rsp_valid=0, alu_op=000, req_ready=1 after release.
//  - addu rs=5 rt=7 -> rsp_valid two edges after accept, rsp_data=12, rsp_err=0.
//  - addiu rs=1 imm=0xFFFF -> rsp_data=0; ori rs=0xF0 imm=0x0F -> 0xFF (zero-extend check).
//  - sra rt=0x80000000 shamt=4 -> 0xF8000000; srlv rs=36 rt=0x100 -> 0x10 (rs[4:0]=4).
//  - funct 0x00 (sll) -> rsp_err=1, rsp_data=0, one edge to rsp_valid; rsp_ready=0 for 5 cycles ->
//    outputs stable, req_ready=0 throughout.
//  - OVERFLOW_TRAP_EN: add 0x7FFFFFFF+1 -> rsp_err=1; without macro same instr -> rsp_err=1 (illegal),
//    addu same operands -> 0x80000000, rsp_err=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALUOp codes, MIPS opcode/funct
// values and FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;

  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: instruction + operands -> ALU A/B/ALUOp and illegal flag.
// OVERFLOW_TRAP_EN adds the trapping add/sub/addi forms and a trap output.
import alu_ctrl_pkg::*;

module alu_issue_decode (
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
`ifdef OVERFLOW_TRAP_EN
  output logic        trap,
`endif
  output logic        illegal
);

  logic [5:0]  opc;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_fields;

  assign opc   = instr[31:26];
  assign funct = instr[5:0];
  assign shamt = instr[10:6];
  assign imm   = instr[15:0];
  // Register-number fields are resolved upstream; only the values arrive here.
  assign unused_fields = ^instr[25:16];

  always_comb begin
    a       = rs_val;
    b       = rt_val;
    op      = ALU_ADD;
    illegal = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    trap    = 1'b0;
`endif
    case (opc)
      OP_RTYPE: begin
        case (funct)
          F_ADDU: op = ALU_ADD;
          F_SUBU: op = ALU_SUB;
          F_AND:  op = ALU_AND;
          F_OR:   op = ALU_OR;
          F_SRL:  begin a = rt_val; b = {27'd0, shamt};       op = ALU_SRL; end
          F_SRA:  begin a = rt_val; b = {27'd0, shamt};       op = ALU_SRA; end
          F_SRLV: begin a = rt_val; b = {27'd0, rs_val[4:0]}; op = ALU_SRL; end
          F_SRAV: begin a = rt_val; b = {27'd0, rs_val[4:0]}; op = ALU_SRA; end
`ifdef OVERFLOW_TRAP_EN
          F_ADD:  begin op = ALU_ADD; trap = 1'b1; end
          F_SUB:  begin op = ALU_SUB; trap = 1'b1; end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin b = {{16{imm[15]}}, imm}; op = ALU_ADD; end
      OP_ANDI:  begin b = {16'd0, imm};         op = ALU_AND; end
      OP_ORI:   begin b = {16'd0, imm};         op = ALU_OR;  end
`ifdef OVERFLOW_TRAP_EN
      OP_ADDI:  begin b = {{16{imm[15]}}, imm}; op = ALU_ADD; trap = 1'b1; end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction, drives the external ALU, returns
// the captured result. OVERFLOW_TRAP_EN enables signed-overflow trapping on add/sub/addi.
import alu_ctrl_pkg::*;

module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs_val,
  input  logic [31:0] req_rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  state_t      state;
  logic [31:0] dec_a, dec_b;
  logic [2:0]  dec_op;
  logic        dec_illegal;
  logic        ovf;

`ifdef OVERFLOW_TRAP_EN
  logic        dec_trap;
  logic        trap_chk;
  logic [31:0] b_eff;

  // Subtraction overflows like an add of the negated operand.
  assign b_eff = (alu_op == ALU_SUB) ? (~alu_b + 32'd1) : alu_b;
  assign ovf   = trap_chk && (alu_a[31] == b_eff[31]) && (alu_c[31] != alu_a[31]);
`else
  assign ovf   = 1'b0;
`endif

  alu_issue_decode u_dec (
    .instr   (req_instr),
    .rs_val  (req_rs_val),
    .rt_val  (req_rt_val),
    .a       (dec_a),
    .b       (dec_b),
    .op      (dec_op),
`ifdef OVERFLOW_TRAP_EN
    .trap    (dec_trap),
`endif
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= ALU_ADD;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
      trap_chk  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_illegal) begin
              // Illegal ops skip the ALU and leave its operands untouched.
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              alu_a  <= dec_a;
              alu_b  <= dec_b;
              alu_op <= dec_op;
`ifdef OVERFLOW_TRAP_EN
              trap_chk <= dec_trap;
`endif
              state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          rsp_data  <= ovf ? 32'd0 : alu_c;
          rsp_err   <= ovf;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
